// File: rtl/cycle_step_controller.sv
// Debug sequencer: debounced step button / run switch -> single-clock cycle_en pulses.
// Optional PC breakpoint halting free-run is enabled by defining STEP_BREAKPOINT_EN.
module cycle_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000,
    parameter int COUNT_W         = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               step_btn,
    input  logic               run_sw,
    input  logic [31:0]        pc,
    input  logic [31:0]        bp_addr,
    input  logic               bp_valid,
    output logic               cycle_en,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [1:0]         state,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    // Index 0 is the step button, index 1 the run switch.
    logic [1:0] raw_in;
    logic [1:0] db_vec;

    assign raw_in = {run_sw, step_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    // Only an unbroken run of differing samples may flip the output.
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg <= '0;
                        db_reg  <= ~db_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    logic step_db_d_reg;
    logic step_req;
    logic run_db;
    logic bp_hit;

    assign step_req = db_vec[0] & ~step_db_d_reg;
    assign run_db   = db_vec[1];

`ifdef STEP_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{pc, bp_addr, bp_valid};
    assign bp_hit           = 1'b0;
`endif

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               en_reg, en_next;
    logic [COUNT_W-1:0] count_reg;

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        en_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (step_req) begin
                    state_next = ST_STEP;
                    en_next    = 1'b1;
                end else if (run_db) begin
                    state_next = ST_RUN;
                    div_next   = '0;
                end
            end
            ST_STEP: begin
                state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (!run_db) begin
                    state_next = ST_IDLE;
                end else if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (bp_hit) begin
                        state_next = ST_HALT;
                    end else begin
                        en_next = 1'b1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            ST_HALT: begin
                if (!run_db) begin
                    state_next = ST_IDLE;
                end else if (step_req) begin
                    state_next = ST_STEP;
                    en_next    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            en_reg        <= 1'b0;
            count_reg     <= '0;
            step_db_d_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            en_reg        <= en_next;
            step_db_d_reg <= db_vec[0];
            if (en_reg) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign cycle_en    = en_reg;
    assign cycle_count = count_reg;
    assign state       = state_reg;

`ifdef STEP_BREAKPOINT_EN
    assign halted = (state_reg == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
